// File: rtl/rep_tx_pkg.sv
// Shared encodings for the repetition-coded serial transmitter.
// Optional parity symbol controlled by REP_TX_PARITY_EN.
package rep_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic SYM_START = 1'b0;
  localparam logic SYM_STOP  = 1'b1;

  // Total clocks on the line for one frame, start through stop.
  function automatic int frame_len(input int data_w, input int rep);
`ifdef REP_TX_PARITY_EN
    return rep * (data_w + 3);
`else
    return rep * (data_w + 2);
`endif
  endfunction

endpackage

// File: rtl/rep_symbol_timer.sv
// Counts the REP clocks each symbol is held on the line; rep_last marks the final one.
module rep_symbol_timer #(
  parameter int REP = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic rep_last
);

  localparam int CW = $clog2(REP);

  logic [CW-1:0] rep_cnt;

  assign rep_last = en && (rep_cnt == CW'(REP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (clr) begin
      rep_cnt <= '0;
    end else if (en) begin
      if (rep_last) rep_cnt <= '0;
      else          rep_cnt <= rep_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rep_serial_tx.sv
// Framed serial transmitter, every symbol held REP clocks for receiver majority voting.
// Define REP_TX_PARITY_EN to insert an even-parity symbol before STOP.
//
//  state  | meaning
//  IDLE   | line high, ready for a word (first clock after STOP also pulses tx_done)
//  START  | start symbol (0) on the line
//  DATA   | payload symbols, MSB first
//  PARITY | even parity of the payload (REP_TX_PARITY_EN only)
//  STOP   | stop symbol (1) on the line
module rep_serial_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  import rep_tx_pkg::*;

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_next;
  logic [BW-1:0]     bit_cnt;
  logic              rep_last;
`ifdef REP_TX_PARITY_EN
  logic              par;
`endif

  assign sh_next = shreg << 1;

  rep_symbol_timer #(.REP(REP)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state != IDLE),
    .clr      (state == IDLE),
    .rep_last (rep_last)
  );

  // tx_out is loaded with the level of the state being entered, so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      tx_out   <= LINE_IDLE;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef REP_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_done <= 1'b0;
          if (tx_valid) begin
            shreg    <= tx_data;
`ifdef REP_TX_PARITY_EN
            par      <= ^tx_data;
`endif
            state    <= START;
            tx_out   <= SYM_START;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (rep_last) begin
            state  <= DATA;
            tx_out <= shreg[DATA_W-1];
          end
        end
        DATA: begin
          if (rep_last) begin
            shreg <= sh_next;
            if (bit_cnt == BW'(DATA_W - 1)) begin
              bit_cnt <= '0;
`ifdef REP_TX_PARITY_EN
              state   <= PARITY;
              tx_out  <= par;
`else
              state   <= STOP;
              tx_out  <= SYM_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= sh_next[DATA_W-1];
            end
          end
        end
`ifdef REP_TX_PARITY_EN
        PARITY: begin
          if (rep_last) begin
            state  <= STOP;
            tx_out <= SYM_STOP;
          end
        end
`endif
        STOP: begin
          if (rep_last) begin
            state    <= IDLE;
            tx_out   <= LINE_IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tx_out   <= LINE_IDLE;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          tx_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rep_serial_tx.sv
// Self-checking bench for rep_serial_tx: scoreboard of accepted words, majority-voting receiver.
module tb_rep_serial_tx;

  import rep_tx_pkg::*;

  localparam int DATA_W = 8;
  localparam int REP    = 3;
  localparam int FL     = frame_len(DATA_W, REP);
  localparam int NSYM   = FL / REP;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_out;
  logic              tx_busy;
  logic              tx_done;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  int  cyc = 0;
  int  frames_done = 0;
  int  start_cyc = 0;
  int  prev_start_cyc = 0;
  bit  flip_en = 1'b0;

  rep_serial_tx #(.DATA_W(DATA_W), .REP(REP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic exp_sym(input logic [DATA_W-1:0] w, input int g);
    if (g == 0) return 1'b0;
    if (g <= DATA_W) return w[DATA_W - g];
    if (g == NSYM - 1) return 1'b1;
    return ^w;
  endfunction

  // Receiver: frames on tx_busy, compares raw samples to the model, then majority-votes.
  int mstate = 0;
  int idx;
  int pat_err;
  int ones[NSYM];
  logic [DATA_W-1:0] cur;
  always @(negedge clk) begin
    logic s;
    logic [DATA_W-1:0] got;
    int g;
    if (!rst_n) begin
      mstate = 0;
    end else begin
      if (mstate == 2) begin
        checks++;
        if (tx_done !== 1'b1 || tx_out !== 1'b1 || tx_ready !== 1'b1) begin
          errors++;
          $display("FAIL done_cycle: done=%b out=%b ready=%b, required 1 1 1", tx_done, tx_out, tx_ready);
        end
        got = '0;
        for (int k = 1; k <= DATA_W; k++) got[DATA_W-k] = (ones[k] > REP/2);
        checks++;
        if (got !== cur) begin
          errors++;
          $display("FAIL voted_word: got %h, required %h", got, cur);
        end
        checks++;
        if ((ones[0] > REP/2) !== 1'b0 || (ones[NSYM-1] > REP/2) !== 1'b1) begin
          errors++;
          $display("FAIL framing: start vote %0d stop vote %0d ones", ones[0], ones[NSYM-1]);
        end
`ifdef REP_TX_PARITY_EN
        checks++;
        if ((ones[NSYM-2] > REP/2) !== (^cur)) begin
          errors++;
          $display("FAIL parity_sym: got %b, required %b", ones[NSYM-2] > REP/2, ^cur);
        end
`endif
        checks++;
        if (pat_err != 0) begin
          errors++;
          $display("FAIL line_pattern: %0d wrong samples for word %h, required 0", pat_err, cur);
        end
        frames_done++;
        mstate = 0;
      end else if (mstate == 0 && tx_busy) begin
        mstate = 1;
        idx = 0;
        pat_err = 0;
        for (int k = 0; k < NSYM; k++) ones[k] = 0;
        prev_start_cyc = start_cyc;
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: frame started with empty scoreboard");
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (mstate == 1) begin
        g = idx / REP;
        if (tx_out !== exp_sym(cur, g)) pat_err++;
        s = tx_out ^ (flip_en && ((idx % REP) == (g % REP)));
        if (s) ones[g]++;
        idx++;
        if (idx == FL) mstate = 2;
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] w);
    int n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready=%b, required 1", tx_ready);
    end
    tx_data  = w;
    tx_valid = 1'b1;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    checks++;
    if (tx_out !== 1'b0 || tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_latency: out=%b busy=%b ready=%b, required 0 1 0", tx_out, tx_busy, tx_ready);
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL frame_timeout: frames %0d, required %0d", frames_done, target);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%b ready=%b busy=%b done=%b, required 1 1 0 0",
               tx_out, tx_ready, tx_busy, tx_done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: out=%b busy=%b, required 1 0", tx_out, tx_busy);
    end
  endtask

  task automatic test_basic();
    int base = frames_done;
    send(8'hA5);
    wait_frames(base + 1);
    send(8'h00);
    send(8'hFF);
    wait_frames(base + 3);
  endtask

  task automatic test_parity();
    int base = frames_done;
    send(8'hA5);
    send(8'h01);
    send(8'h7F);
    wait_frames(base + 3);
  endtask

  task automatic test_back_to_back();
    int base = frames_done;
    int n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back(8'h3C);
    @(posedge clk);
    #1;
    tx_data = 8'hC3;
    exp_q.push_back(8'hC3);
    n = 0;
    @(negedge clk);
    while (tx_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_timeout: done=%b, required 1", tx_done);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    wait_frames(base + 2);
    checks++;
    if (start_cyc - prev_start_cyc != FL + 1) begin
      errors++;
      $display("FAIL b2b_gap: frame spacing %0d clocks, required %0d", start_cyc - prev_start_cyc, FL + 1);
    end
  endtask

  task automatic test_data_stable();
    int base = frames_done;
    send(8'h96);
    repeat (FL) begin
      @(negedge clk);
      tx_data = DATA_W'($urandom);
    end
    wait_frames(base + 1);
  endtask

  task automatic test_reset_mid();
    int base;
    send(8'hAA);
    repeat (REP * 5 + 1) @(negedge clk);
    base = frames_done;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out=%b ready=%b busy=%b done=%b, required 1 1 0 0",
               tx_out, tx_ready, tx_busy, tx_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h0F);
    wait_frames(base + 1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d entries, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef REP_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_data_stable();
    test_reset_mid();
    flip_en = 1'b1;
    test_basic();
`ifdef REP_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    flip_en = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
